// File: rtl/buffer_64_to_512_pkg.sv
// Shared sizes and types for the 64-to-512 line assembler.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package buf_pkg;

    localparam int LANES  = 8;
    localparam int LANE_W = 64;
    localparam int LINE_W = LANES * LANE_W;

    typedef logic [LINE_W-1:0]         line_t;
    typedef logic [LANES-1:0]          lane_mask_t;
    typedef logic [$clog2(LANES)-1:0]  wcnt_t;

    localparam wcnt_t LAST_LANE = wcnt_t'(LANES - 1);

    // One-hot marker for the lane a word is being written into.
    function automatic lane_mask_t lane_bit(input wcnt_t idx);
        return lane_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/buffer_64_to_512_if.sv
// Word-in / line-out bundle for buffer_64_to_512; optional flush under BUF64_FLUSH_EN.
// Latency: wiring only.
// Backpressure: full stalls the word side, empty gates the line side.
interface buffer_64_to_512_if #(parameter int DEPTH = 4);
    import buf_pkg::*;

    logic [LANE_W-1:0]      data_in;
    logic                   wr_enable;
    logic                   full;
    logic                   full_n;
    line_t                  data_out;
    logic                   rd_enable;
    logic                   empty;
    logic [$clog2(DEPTH):0] level;
`ifdef BUF64_FLUSH_EN
    logic                   flush;
    lane_mask_t             lane_mask;

    modport master (output data_in, wr_enable, rd_enable, flush,
                    input  full, full_n, data_out, empty, level, lane_mask);
    modport slave  (input  data_in, wr_enable, rd_enable, flush,
                    output full, full_n, data_out, empty, level, lane_mask);
`else
    modport master (output data_in, wr_enable, rd_enable,
                    input  full, full_n, data_out, empty, level);
    modport slave  (input  data_in, wr_enable, rd_enable,
                    output full, full_n, data_out, empty, level);
`endif

endinterface

// File: rtl/buffer_64_to_512_line_fifo.sv
// Single-clock first-word-fall-through FIFO of DEPTH entries, W bits each.
// Latency: a push is visible at the head the cycle after its edge.
// Backpressure: pushes while full and pops while empty are dropped; clear wins.
module line_fifo_sc #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head_dat,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_almost_full,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push_ok = i_push && !o_full  && !i_clr;
    assign w_pop_ok  = i_pop  && !o_empty && !i_clr;

    // Line storage is never reset; the head is only meaningful when not empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; a clear empties the FIFO outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= ptr_inc(r_wptr);
            if (w_pop_ok)  r_rptr <= ptr_inc(r_rptr);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat    = r_mem[r_rptr];
    assign o_empty       = (r_count == '0);
    assign o_full        = (r_count == CW'(DEPTH));
    assign o_almost_full = (r_count >= CW'(DEPTH - 1));
    assign o_level       = r_count;

endmodule

// File: rtl/buffer_64_to_512.sv
// Packs 64-bit words into 512-bit lines (lane 0 first) and queues them; BUF64_FLUSH_EN adds partial-line flush.
// Latency: a line is at data_out the cycle after its eighth (or flushing) word's edge.
// Backpressure: full drops wr_enable/flush; rd_enable on empty is ignored; clr overrides all.
module buffer_64_to_512
    import buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    buffer_64_to_512_if.slave bus
);
    localparam int FW = LINE_W + LANES;

    wcnt_t                  r_wcnt;
    line_t                  r_lanes;
`ifdef BUF64_FLUSH_EN
    lane_mask_t             r_mask;
`endif
    logic                   w_wr_acc;
    logic                   w_push;
    logic                   w_pop;
    line_t                  w_line_next;
    lane_mask_t             w_mask_next;
    logic [FW-1:0]          w_head;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_afull;
    logic [$clog2(DEPTH):0] w_level;
    line_t                  w_data_out;

    assign w_wr_acc = bus.wr_enable && !w_full && !clr;
    assign w_pop    = bus.rd_enable && !w_empty && !clr;

    // Line as it would look after this edge's word lands in lane r_wcnt.
    always_comb begin
        w_line_next = r_lanes;
        if (w_wr_acc) begin
            w_line_next[r_wcnt*LANE_W +: LANE_W] = bus.data_in;
        end
    end

`ifdef BUF64_FLUSH_EN
    // Track written lanes; a flush pushes whatever is there, but never an empty line.
    always_comb begin
        w_mask_next = r_mask;
        if (w_wr_acc) begin
            w_mask_next = r_mask | lane_bit(r_wcnt);
        end
        w_push = (w_wr_acc && (r_wcnt == LAST_LANE)) ||
                 (bus.flush && !w_full && !clr && (w_wr_acc || (r_wcnt != '0)));
    end
`else
    // Only complete lines exist, so every pushed line carries all lanes.
    always_comb begin
        w_mask_next = '1;
        w_push      = w_wr_acc && (r_wcnt == LAST_LANE);
    end
`endif

    // Assembly state restarts at lane 0 after every push or clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt  <= '0;
            r_lanes <= '0;
`ifdef BUF64_FLUSH_EN
            r_mask  <= '0;
`endif
        end else if (clr || w_push) begin
            r_wcnt  <= '0;
            r_lanes <= '0;
`ifdef BUF64_FLUSH_EN
            r_mask  <= '0;
`endif
        end else if (w_wr_acc) begin
            r_wcnt  <= r_wcnt + 1'b1;
            r_lanes <= w_line_next;
`ifdef BUF64_FLUSH_EN
            r_mask  <= w_mask_next;
`endif
        end
    end

    line_fifo_sc #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_line_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_clr         (clr),
        .i_push        (w_push),
        .i_push_dat    ({w_mask_next, w_line_next}),
        .i_pop         (w_pop),
        .o_head_dat    (w_head),
        .o_empty       (w_empty),
        .o_full        (w_full),
        .o_almost_full (w_afull),
        .o_level       (w_level)
    );

    // Head lanes are shown only when a line exists and that lane was written.
    always_comb begin
        w_data_out = '0;
        for (int k = 0; k < LANES; k++) begin
            if (!w_empty && w_head[LINE_W + k]) begin
                w_data_out[k*LANE_W +: LANE_W] = w_head[k*LANE_W +: LANE_W];
            end
        end
    end

    assign bus.data_out  = w_data_out;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.full_n    = w_afull;
    assign bus.level     = w_level;
`ifdef BUF64_FLUSH_EN
    assign bus.lane_mask = w_empty ? '0 : w_head[FW-1:LINE_W];
`endif

endmodule

// File: tb/tb_buffer_64_to_512.sv
// Directed bench for buffer_64_to_512 at DEPTH=2: vector table plus corner sequences.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: fill-to-full, drop-on-full and continuous streaming are exercised.
module tb_buffer_64_to_512;
    import buf_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    buffer_64_to_512_if #(.DEPTH(DEPTH)) bus ();

    buffer_64_to_512 #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic        wr;
        logic [63:0] din;
        logic        rd;
        logic        e_empty;
        logic        e_full;
        logic        e_fn;
        int          e_lvl;
        logic        chk_dat;
        logic [63:0] e_lo;
        logic [63:0] e_hi;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input logic wr, input logic [63:0] din, input logic rd);
        bus.wr_enable = wr;
        bus.data_in   = din;
        bus.rd_enable = rd;
    endtask

    function automatic void add(input logic wr, input logic [63:0] din, input logic rd,
                                input logic ee, input logic ef, input logic efn, input int el,
                                input logic cd, input logic [63:0] lo, input logic [63:0] hi);
        vec_t v;
        v.wr = wr; v.din = din; v.rd = rd;
        v.e_empty = ee; v.e_full = ef; v.e_fn = efn; v.e_lvl = el;
        v.chk_dat = cd; v.e_lo = lo; v.e_hi = hi;
        tbl.push_back(v);
    endfunction

    // Writes one full line of words base..base+7.
    task automatic write_line(input logic [63:0] base);
        for (int k = 0; k < 8; k++) begin
            setin(1'b1, base + 64'(k), 1'b0);
            tick();
        end
        setin(1'b0, 64'h0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int popped;
        setin(1'b0, 64'h0, 1'b0);
`ifdef BUF64_FLUSH_EN
        bus.flush = 1'b0;
`endif
        // ---- reset values while rst is held low
        #2 rst = 1'b0;
        #1;
        chk("rst_empty",  bus.empty,  1'b1);
        chk("rst_full",   bus.full,   1'b0);
        chk("rst_full_n", bus.full_n, 1'b0);
        chk("rst_level",  bus.level,  0);
        chk("rst_data",   bus.data_out, '0);
`ifdef BUF64_FLUSH_EN
        chk("rst_mask",   bus.lane_mask, 8'h00);
`endif
        tick();
        tick();
        rst = 1'b1;

        // ---- vector table: fill to full, drop on full, pop, push+pop, empty read
        for (int i = 0; i < 7; i++) add(1, 64'(i), 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 64'h7, 0, 0, 0, 1, 1, 1, 64'h0, 64'h7);
        for (int i = 0; i < 7; i++) add(1, 64'h10 + 64'(i), 0, 0, 0, 1, 1, 1, 64'h0, 64'h7);
        add(1, 64'h17, 0, 0, 1, 1, 2, 1, 64'h0, 64'h7);
        add(1, 64'h99, 0, 0, 1, 1, 2, 1, 64'h0, 64'h7);
        add(0, 64'h0,  1, 0, 0, 1, 1, 1, 64'h10, 64'h17);
        for (int i = 0; i < 7; i++) add(1, 64'h20 + 64'(i), 0, 0, 0, 1, 1, 1, 64'h10, 64'h17);
        add(1, 64'h27, 1, 0, 0, 1, 1, 1, 64'h20, 64'h27);
        add(0, 64'h0,  1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 64'h0,  1, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            setin(tbl[i].wr, tbl[i].din, tbl[i].rd);
            tick();
            chk($sformatf("v%0d_empty", i),  bus.empty,  tbl[i].e_empty);
            chk($sformatf("v%0d_full", i),   bus.full,   tbl[i].e_full);
            chk($sformatf("v%0d_full_n", i), bus.full_n, tbl[i].e_fn);
            chk($sformatf("v%0d_level", i),  bus.level,  tbl[i].e_lvl);
            if (tbl[i].chk_dat) begin
                chk($sformatf("v%0d_lane0", i), bus.data_out[63:0],    tbl[i].e_lo);
                chk($sformatf("v%0d_lane7", i), bus.data_out[511:448], tbl[i].e_hi);
            end
        end
        setin(1'b0, 64'h0, 1'b0);

        // ---- reset mid-line discards the partial line
        for (int k = 0; k < 3; k++) begin
            setin(1'b1, 64'h51 + 64'(k), 1'b0);
            tick();
        end
        setin(1'b0, 64'h0, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_level", bus.level, 0);
        chk("midrst_empty", bus.empty, 1'b1);
        tick();
        rst = 1'b1;
        write_line(64'hA0);
        chk("midrst_line_level", bus.level, 1);
        chk("midrst_lane0", bus.data_out[63:0],    64'hA0);
        chk("midrst_lane1", bus.data_out[127:64],  64'hA1);
        chk("midrst_lane7", bus.data_out[511:448], 64'hA7);
        setin(1'b0, 64'h0, 1'b1);
        tick();
        setin(1'b0, 64'h0, 1'b0);
        chk("midrst_drain_empty", bus.empty, 1'b1);

        // ---- clr on the edge that would push, with a line already queued
        write_line(64'hC0);
        for (int k = 0; k < 7; k++) begin
            setin(1'b1, 64'hD0 + 64'(k), 1'b0);
            tick();
        end
        chk("preclr_level", bus.level, 1);
        setin(1'b1, 64'hD7, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        setin(1'b0, 64'h0, 1'b0);
        chk("clr_level", bus.level, 0);
        chk("clr_empty", bus.empty, 1'b1);
        chk("clr_full_n", bus.full_n, 1'b0);
        write_line(64'hE0);
        chk("postclr_lane0", bus.data_out[63:0],    64'hE0);
        chk("postclr_lane7", bus.data_out[511:448], 64'hE7);
        setin(1'b0, 64'h0, 1'b1);
        tick();
        setin(1'b0, 64'h0, 1'b0);

`ifdef BUF64_FLUSH_EN
        // ---- partial-line flush, idle flush, flush together with a write
        for (int k = 0; k < 3; k++) begin
            setin(1'b1, 64'hF0 + 64'(k), 1'b0);
            tick();
        end
        setin(1'b0, 64'h0, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_level", bus.level, 1);
        chk("flush_mask",  bus.lane_mask, 8'h07);
        chk("flush_lane0", bus.data_out[63:0], 64'hF0);
        chk("flush_lane2", bus.data_out[191:128], 64'hF2);
        chk("flush_upper_zero", bus.data_out[511:192], '0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_idle_level", bus.level, 1);
        write_line(64'h30);
        setin(1'b0, 64'h0, 1'b1);
        tick();
        setin(1'b0, 64'h0, 1'b0);
        chk("flush_next_lane0", bus.data_out[63:0], 64'h30);
        chk("flush_next_mask",  bus.lane_mask, 8'hFF);
        setin(1'b0, 64'h0, 1'b1);
        tick();
        setin(1'b1, 64'h40, 1'b0);
        tick();
        setin(1'b1, 64'h41, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        setin(1'b0, 64'h0, 1'b0);
        chk("flushwr_mask",  bus.lane_mask, 8'h03);
        chk("flushwr_lane1", bus.data_out[127:64], 64'h41);
        setin(1'b0, 64'h0, 1'b1);
        tick();
        setin(1'b0, 64'h0, 1'b0);
`endif

        // ---- continuous write and pop across pointer wrap
        chk("stream_start_empty", bus.empty, 1'b1);
        popped = 0;
        for (int cyc = 0; cyc < 56; cyc++) begin
            setin(cyc < 48, 64'((cyc / 8) * 256 + (cyc % 8)), 1'b1);
            if (!bus.empty) begin
                chk($sformatf("stream_l%0d_lane0", popped), bus.data_out[63:0],    64'(popped * 256));
                chk($sformatf("stream_l%0d_lane7", popped), bus.data_out[511:448], 64'(popped * 256 + 7));
                popped++;
            end
            chk($sformatf("stream_c%0d_level_le1", cyc), bus.level <= 1, 1'b1);
            tick();
        end
        setin(1'b0, 64'h0, 1'b0);
        chk("stream_lines_popped", popped, 6);
        chk("stream_end_empty", bus.empty, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
